dccm_port_arb: RTL and testbench

DCCM_PORT_ARB -- requirements
Module: dccm_port_arb

---
 rtl/dccm_port_arb_pkg.sv | 28 ++
 rtl/dccm_port_arb_starve_ctr.sv | 43 ++++
 rtl/dff_rst.sv | 21 ++
 rtl/dccm_port_arb.sv | 194 +++++++++++++++++++
 tb/tb_dccm_port_arb.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/dccm_port_arb_pkg.sv
// Shared types and defaults for the DCCM port arbiter: FSM state encoding,
// counter width, default parameters and the IDLE-state DMA ready rule.
package dccm_port_arb_pkg;

    localparam int XLEN_DEF       = 32;
    localparam int STARVE_MAX_DEF = 8;
    localparam int CNT_W          = 8;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_GRANT = 2'd2;

    // In IDLE the DMA only loses the port it actually wants to use.
    function automatic logic idle_ready(
        input logic dma_write,
        input logic lsu_wen,
        input logic lsu_ren
    );
        logic rdy;
        if (dma_write) begin
            rdy = ~lsu_wen;
        end else begin
            rdy = ~lsu_ren;
        end
        return rdy;
    endfunction

endpackage

// File: rtl/dccm_port_arb_starve_ctr.sv
// Saturating up-counter of DMA wait cycles; clear has priority over increment.
module starve_ctr
    import dccm_port_arb_pkg::*;
#(
    parameter int MAX = STARVE_MAX_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt,
    output logic             sat
);

    localparam logic [CNT_W-1:0] MAX_C = 8'(MAX);

    logic [CNT_W-1:0] cnt_nxt;

    assign sat = (cnt == MAX_C);

    // Next count: clear wins, otherwise count up and hold at MAX
    always_comb begin
        cnt_nxt = cnt;
        if (clr) begin
            cnt_nxt = {CNT_W{1'b0}};
        end else if (inc && !sat) begin
            cnt_nxt = cnt + 8'd1;
        end else begin
            cnt_nxt = cnt;
        end
    end

    dff_rst #(
        .W       (CNT_W),
        .RST_VAL ({CNT_W{1'b0}})
    ) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (cnt_nxt),
        .q     (cnt)
    );

endmodule

// File: rtl/dff_rst.sv
// Generic D flop bank with synchronous active-low reset to a fixed value.
module dff_rst #(
    parameter int         W       = 1,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Capture d every cycle; reset loads RST_VAL
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q <= RST_VAL;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/dccm_port_arb.sv
// DCCM port arbiter: LSU and DMA share independent read and write ports.
// LSU wins each port by default; a starved DMA forces a drain of the LSU
// followed by one guaranteed DMA grant cycle.
module dccm_port_arb
    import dccm_port_arb_pkg::*;
#(
    parameter int XLEN       = XLEN_DEF,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    // LSU side
    input  logic [XLEN-1:0] lsu_dccm_raddr,
    input  logic            lsu_dccm_rvalid_in,
    input  logic [XLEN-1:0] lsu_dccm_waddr,
    input  logic [XLEN-1:0] lsu_dccm_wdata,
    input  logic            lsu_dccm_wen,
    input  logic            lsu_busy,
    output logic [XLEN-1:0] lsu_dccm_rdata,
    output logic            lsu_dccm_rvalid_out,
    output logic            arb_lsu_stall,
    // DMA side
    input  logic            dma_req_valid,
    output logic            dma_req_ready,
    input  logic            dma_req_write,
    input  logic [XLEN-1:0] dma_req_addr,
    input  logic [XLEN-1:0] dma_req_wdata,
    output logic            dma_rsp_valid,
    output logic [XLEN-1:0] dma_rsp_rdata,
    // Memory side
    output logic [XLEN-1:0] dccm_raddr,
    output logic            dccm_ren,
    input  logic [XLEN-1:0] dccm_rdata,
    input  logic            dccm_rvalid,
    output logic [XLEN-1:0] dccm_waddr,
    output logic [XLEN-1:0] dccm_wdata,
    output logic            dccm_wen
);

    localparam logic [CNT_W-1:0] MAX_C = 8'(STARVE_MAX);

    logic [1:0]       fsm_state;
    logic [1:0]       fsm_state_nxt;
    logic [CNT_W-1:0] starve_cnt;
    logic             starve_sat;
    logic             cnt_inc;
    logic             cnt_clr;
    logic             rsp_owner;
    logic             in_drain;
    logic             in_grant;
    logic             dma_xfer;
    logic             dma_wr_xfer;
    logic             dma_rd_xfer;
    logic             lsu_rd_fwd;
    logic             lsu_wr_fwd;

    assign in_drain = (fsm_state == ST_DRAIN);
    assign in_grant = (fsm_state == ST_GRANT);

    // DMA ready: port-aware in IDLE, closed while draining, forced open in GRANT
    always_comb begin
        dma_req_ready = 1'b0;
        case (fsm_state)
            ST_IDLE:  dma_req_ready = idle_ready(dma_req_write, lsu_dccm_wen, lsu_dccm_rvalid_in);
            ST_DRAIN: dma_req_ready = 1'b0;
            ST_GRANT: dma_req_ready = 1'b1;
            default:  dma_req_ready = 1'b0;
        endcase
    end

    assign dma_xfer    = dma_req_valid & dma_req_ready;
    assign dma_wr_xfer = dma_xfer & dma_req_write;
    assign dma_rd_xfer = dma_xfer & ~dma_req_write;

    // LSU reaches a port only if the DMA does not own it and we are not in GRANT
    assign lsu_rd_fwd = lsu_dccm_rvalid_in & ~in_grant & ~dma_rd_xfer;
    assign lsu_wr_fwd = lsu_dccm_wen & ~in_grant & ~dma_wr_xfer;

    assign arb_lsu_stall = in_drain | in_grant;

    // Read port mux: DMA transfer first, then LSU, else all zero
    always_comb begin
        dccm_ren   = 1'b0;
        dccm_raddr = {XLEN{1'b0}};
        if (dma_rd_xfer) begin
            dccm_ren   = 1'b1;
            dccm_raddr = dma_req_addr;
        end else if (lsu_rd_fwd) begin
            dccm_ren   = 1'b1;
            dccm_raddr = lsu_dccm_raddr;
        end else begin
            dccm_ren   = 1'b0;
            dccm_raddr = {XLEN{1'b0}};
        end
    end

    // Write port mux: DMA transfer first, then LSU, else all zero
    always_comb begin
        dccm_wen   = 1'b0;
        dccm_waddr = {XLEN{1'b0}};
        dccm_wdata = {XLEN{1'b0}};
        if (dma_wr_xfer) begin
            dccm_wen   = 1'b1;
            dccm_waddr = dma_req_addr;
            dccm_wdata = dma_req_wdata;
        end else if (lsu_wr_fwd) begin
            dccm_wen   = 1'b1;
            dccm_waddr = lsu_dccm_waddr;
            dccm_wdata = lsu_dccm_wdata;
        end else begin
            dccm_wen   = 1'b0;
            dccm_waddr = {XLEN{1'b0}};
            dccm_wdata = {XLEN{1'b0}};
        end
    end

    // Starvation counter: count blocked cycles; reset on transfer, abandoned
    // drain, or leaving GRANT so a missed grant cannot retrigger immediately
    assign cnt_inc = dma_req_valid & ~dma_req_ready;
    assign cnt_clr = dma_xfer | (in_drain & ~dma_req_valid) | in_grant;

    starve_ctr #(
        .MAX (STARVE_MAX)
    ) u_starve_ctr (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (cnt_inc),
        .clr   (cnt_clr),
        .cnt   (starve_cnt),
        .sat   (starve_sat)
    );

    // FSM next state: starve -> drain LSU -> one grant cycle -> idle
    always_comb begin
        fsm_state_nxt = fsm_state;
        case (fsm_state)
            ST_IDLE: begin
                if (starve_sat && (starve_cnt == MAX_C)) begin
                    fsm_state_nxt = ST_DRAIN;
                end else begin
                    fsm_state_nxt = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (!dma_req_valid) begin
                    fsm_state_nxt = ST_IDLE;
                end else if (!lsu_busy) begin
                    fsm_state_nxt = ST_GRANT;
                end else begin
                    fsm_state_nxt = ST_DRAIN;
                end
            end
            ST_GRANT: fsm_state_nxt = ST_IDLE;
            default:  fsm_state_nxt = ST_IDLE;
        endcase
    end

    dff_rst #(
        .W       (2),
        .RST_VAL (ST_IDLE)
    ) u_fsm_state (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (fsm_state_nxt),
        .q     (fsm_state)
    );

    // Remember who owns the read data returning next cycle
    dff_rst #(
        .W       (1),
        .RST_VAL (1'b0)
    ) u_rsp_owner (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (dma_rd_xfer),
        .q     (rsp_owner)
    );

    // Route returning read data to its owner; the other side sees zeros
    always_comb begin
        dma_rsp_valid       = 1'b0;
        dma_rsp_rdata       = {XLEN{1'b0}};
        lsu_dccm_rvalid_out = 1'b0;
        lsu_dccm_rdata      = {XLEN{1'b0}};
        if (rsp_owner) begin
            dma_rsp_valid = dccm_rvalid;
            dma_rsp_rdata = dccm_rdata;
        end else begin
            lsu_dccm_rvalid_out = dccm_rvalid;
            lsu_dccm_rdata      = dccm_rdata;
        end
    end

endmodule

// File: tb/tb_dccm_port_arb.sv
// Directed bench for dccm_port_arb: hand-computed expectations checked with
// immediate assertions after inputs settle, away from the clock edge.
module tb_dccm_port_arb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] lsu_dccm_raddr;
    logic        lsu_dccm_rvalid_in;
    logic [31:0] lsu_dccm_waddr;
    logic [31:0] lsu_dccm_wdata;
    logic        lsu_dccm_wen;
    logic        lsu_busy;
    logic [31:0] lsu_dccm_rdata;
    logic        lsu_dccm_rvalid_out;
    logic        arb_lsu_stall;
    logic        dma_req_valid;
    logic        dma_req_ready;
    logic        dma_req_write;
    logic [31:0] dma_req_addr;
    logic [31:0] dma_req_wdata;
    logic        dma_rsp_valid;
    logic [31:0] dma_rsp_rdata;
    logic [31:0] dccm_raddr;
    logic        dccm_ren;
    logic [31:0] dccm_rdata;
    logic        dccm_rvalid;
    logic [31:0] dccm_waddr;
    logic [31:0] dccm_wdata;
    logic        dccm_wen;

    int vectors = 0;
    int errors  = 0;

    dccm_port_arb #(.XLEN(32), .STARVE_MAX(8)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .lsu_dccm_raddr      (lsu_dccm_raddr),
        .lsu_dccm_rvalid_in  (lsu_dccm_rvalid_in),
        .lsu_dccm_waddr      (lsu_dccm_waddr),
        .lsu_dccm_wdata      (lsu_dccm_wdata),
        .lsu_dccm_wen        (lsu_dccm_wen),
        .lsu_busy            (lsu_busy),
        .lsu_dccm_rdata      (lsu_dccm_rdata),
        .lsu_dccm_rvalid_out (lsu_dccm_rvalid_out),
        .arb_lsu_stall       (arb_lsu_stall),
        .dma_req_valid       (dma_req_valid),
        .dma_req_ready       (dma_req_ready),
        .dma_req_write       (dma_req_write),
        .dma_req_addr        (dma_req_addr),
        .dma_req_wdata       (dma_req_wdata),
        .dma_rsp_valid       (dma_rsp_valid),
        .dma_rsp_rdata       (dma_rsp_rdata),
        .dccm_raddr          (dccm_raddr),
        .dccm_ren            (dccm_ren),
        .dccm_rdata          (dccm_rdata),
        .dccm_rvalid         (dccm_rvalid),
        .dccm_waddr          (dccm_waddr),
        .dccm_wdata          (dccm_wdata),
        .dccm_wen            (dccm_wen)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        lsu_dccm_raddr     = 32'h0;
        lsu_dccm_rvalid_in = 1'b0;
        lsu_dccm_waddr     = 32'h0;
        lsu_dccm_wdata     = 32'h0;
        lsu_dccm_wen       = 1'b0;
        lsu_busy           = 1'b0;
        dma_req_valid      = 1'b0;
        dma_req_write      = 1'b0;
        dma_req_addr       = 32'h0;
        dma_req_wdata      = 32'h0;
        dccm_rdata         = 32'h0;
        dccm_rvalid        = 1'b0;
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        // Reset state
        chk("rst_state", dut.fsm_state, 2'd0);
        chk("rst_cnt", dut.starve_cnt, 8'd0);
        chk("rst_stall", arb_lsu_stall, 1'b0);
        chk("rst_rsp_valid", dma_rsp_valid, 1'b0);
        chk("rst_ren", dccm_ren, 1'b0);
        chk("rst_wen", dccm_wen, 1'b0);
        rst_n = 1'b1;
        tick();

        // DMA read 0x100 with LSU idle: issued now, response next cycle
        dma_req_valid = 1'b1;
        dma_req_addr  = 32'h100;
        #1;
        chk("dmard_ready", dma_req_ready, 1'b1);
        chk("dmard_ren", dccm_ren, 1'b1);
        chk("dmard_raddr", dccm_raddr, 32'h100);
        tick();
        idle_inputs();
        dccm_rvalid = 1'b1;
        dccm_rdata  = 32'hCAFE_0100;
        #1;
        chk("dmard_rsp_valid", dma_rsp_valid, 1'b1);
        chk("dmard_rsp_data", dma_rsp_rdata, 32'hCAFE_0100);
        chk("dmard_lsu_rvalid", lsu_dccm_rvalid_out, 1'b0);
        tick();
        // Owner returns to LSU the cycle after
        chk("own_lsu_rvalid", lsu_dccm_rvalid_out, 1'b1);
        chk("own_lsu_rdata", lsu_dccm_rdata, 32'hCAFE_0100);
        chk("own_dma_valid", dma_rsp_valid, 1'b0);
        idle_inputs();

        // LSU read 0x40 vs DMA read 0x80: LSU wins, DMA waits
        lsu_dccm_rvalid_in = 1'b1;
        lsu_dccm_raddr     = 32'h40;
        dma_req_valid      = 1'b1;
        dma_req_addr       = 32'h80;
        #1;
        chk("rdconf_raddr", dccm_raddr, 32'h40);
        chk("rdconf_ready", dma_req_ready, 1'b0);
        tick();
        chk("rdconf_cnt", dut.starve_cnt, 8'd1);
        idle_inputs();
        tick();
        chk("rdconf_cnt_hold", dut.starve_cnt, 8'd1);

        // LSU write 0x10 with DMA read 0x20: both issue, response to DMA
        lsu_dccm_wen   = 1'b1;
        lsu_dccm_waddr = 32'h10;
        lsu_dccm_wdata = 32'h55;
        dma_req_valid  = 1'b1;
        dma_req_addr   = 32'h20;
        #1;
        chk("mix1_wen", dccm_wen, 1'b1);
        chk("mix1_waddr", dccm_waddr, 32'h10);
        chk("mix1_wdata", dccm_wdata, 32'h55);
        chk("mix1_ren", dccm_ren, 1'b1);
        chk("mix1_raddr", dccm_raddr, 32'h20);
        tick();
        chk("mix1_cnt_clr", dut.starve_cnt, 8'd0);
        idle_inputs();
        dccm_rvalid = 1'b1;
        dccm_rdata  = 32'h2020;
        #1;
        chk("mix1_rsp_dma", dma_rsp_valid, 1'b1);
        chk("mix1_rsp_lsu", lsu_dccm_rvalid_out, 1'b0);
        tick();
        idle_inputs();

        // LSU read 0x44 with DMA write 0x88: both issue
        lsu_dccm_rvalid_in = 1'b1;
        lsu_dccm_raddr     = 32'h44;
        dma_req_valid      = 1'b1;
        dma_req_write      = 1'b1;
        dma_req_addr       = 32'h88;
        dma_req_wdata      = 32'h1234;
        #1;
        chk("mix2_ready", dma_req_ready, 1'b1);
        chk("mix2_raddr", dccm_raddr, 32'h44);
        chk("mix2_waddr", dccm_waddr, 32'h88);
        chk("mix2_wdata", dccm_wdata, 32'h1234);
        tick();
        idle_inputs();
        tick();

        // DMA write starved by LSU writes, then drain and forced grant
        lsu_dccm_wen   = 1'b1;
        lsu_dccm_waddr = 32'h30;
        lsu_dccm_wdata = 32'h33;
        lsu_busy       = 1'b1;
        dma_req_valid  = 1'b1;
        dma_req_write  = 1'b1;
        dma_req_addr   = 32'h200;
        dma_req_wdata  = 32'hDEAD;
        #1;
        chk("starve_ready", dma_req_ready, 1'b0);
        chk("starve_waddr", dccm_waddr, 32'h30);
        for (int i = 0; i < 8; i++) begin
            tick();
        end
        chk("starve_cnt8", dut.starve_cnt, 8'd8);
        chk("starve_idle", dut.fsm_state, 2'd0);
        tick();
        chk("drain1_state", dut.fsm_state, 2'd1);
        chk("drain1_stall", arb_lsu_stall, 1'b1);
        chk("drain1_cnt_sat", dut.starve_cnt, 8'd8);
        lsu_dccm_wen = 1'b0;
        #1;
        chk("drain1_ready", dma_req_ready, 1'b0);
        tick();
        chk("drain2_state", dut.fsm_state, 2'd1);
        chk("drain2_stall", arb_lsu_stall, 1'b1);
        tick();
        chk("drain3_state", dut.fsm_state, 2'd1);
        lsu_busy = 1'b0;
        tick();
        chk("grant_state", dut.fsm_state, 2'd2);
        lsu_dccm_wen       = 1'b1;
        lsu_dccm_rvalid_in = 1'b1;
        lsu_dccm_raddr     = 32'h60;
        #1;
        chk("grant_ready", dma_req_ready, 1'b1);
        chk("grant_stall", arb_lsu_stall, 1'b1);
        chk("grant_wen", dccm_wen, 1'b1);
        chk("grant_waddr", dccm_waddr, 32'h200);
        chk("grant_wdata", dccm_wdata, 32'hDEAD);
        chk("grant_no_lsu_ren", dccm_ren, 1'b0);
        tick();
        chk("post_grant_state", dut.fsm_state, 2'd0);
        chk("post_grant_cnt", dut.starve_cnt, 8'd0);
        chk("post_grant_stall", arb_lsu_stall, 1'b0);
        idle_inputs();
        tick();

        // Reset in the cycle after a DMA read drops the response
        dma_req_valid = 1'b1;
        dma_req_addr  = 32'h300;
        tick();
        idle_inputs();
        rst_n       = 1'b0;
        dccm_rvalid = 1'b1;
        dccm_rdata  = 32'h77;
        tick();
        chk("rstrd_rsp_valid", dma_rsp_valid, 1'b0);
        chk("rstrd_state", dut.fsm_state, 2'd0);
        chk("rstrd_stall", arb_lsu_stall, 1'b0);
        rst_n = 1'b1;
        idle_inputs();
        tick();

        // DMA valid drops while draining: back to IDLE, counter cleared
        lsu_dccm_rvalid_in = 1'b1;
        lsu_dccm_raddr     = 32'h50;
        lsu_busy           = 1'b1;
        dma_req_valid      = 1'b1;
        dma_req_addr       = 32'h90;
        for (int i = 0; i < 9; i++) begin
            tick();
        end
        chk("abort_drain", dut.fsm_state, 2'd1);
        dma_req_valid      = 1'b0;
        lsu_dccm_rvalid_in = 1'b0;
        tick();
        chk("abort_state", dut.fsm_state, 2'd0);
        chk("abort_stall", arb_lsu_stall, 1'b0);
        chk("abort_cnt", dut.starve_cnt, 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
